// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state codes and constants for the instruction-fetch front end
package fetch_pkg;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  localparam int unsigned INSTR_STEP = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush and occupancy count, wrap-around pointers
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = 96
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign do_pop = pop_i & (cnt_q != '0);
  // a push into a full queue is accepted only when the head leaves the same cycle
  assign do_push = push_i & ((cnt_q != (AW+1)'(DEPTH)) | do_pop);
  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_q <= rd_q;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, SRAM read issue and fetch queue feeding decode.
// FETCH_BYPASS_EN: a response arriving at an empty queue with decode ready goes straight to out_*.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       redirect_valid,
  input  logic [DATA_W-1:0]          redirect_pc,
  output logic [DATA_W-1:0]          imem_addr,
  output logic                       imem_ren,
  input  logic [INSTR_W-1:0]         imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [DATA_W-1:0]          out_pc,
  output logic [DATA_W-1:0]          out_updated_pc,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [DATA_W-1:0] STEP = DATA_W'(INSTR_STEP);
  logic [0:0] state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d, resp_pc_q, tgt;
  logic inflight_q, issue, bypass, push, pop;
  logic [DATA_W+INSTR_W-1:0] head;
  logic [CW-1:0] fifo_cnt;
  assign tgt = redirect_pc & ~DATA_W'(3);
  // credit counts the word still in the SRAM pipe so a full queue never overflows
  assign issue = enable & (redirect_valid | ((state_q == RUN) & ((fifo_cnt + CW'(inflight_q)) < CW'(DEPTH))));
  assign imem_ren = issue;
  assign imem_addr = redirect_valid ? tgt : pc_q;
  assign state_d = enable ? RUN : IDLE;
  assign pc_d = issue ? imem_addr + STEP : redirect_valid ? tgt : pc_q;
`ifdef FETCH_BYPASS_EN
  assign bypass = inflight_q & ~redirect_valid & out_ready & (fifo_cnt == '0);
`else
  assign bypass = 1'b0;
`endif
  // a redirect kills the response arriving this cycle and any same-cycle pop
  assign push = inflight_q & ~redirect_valid & ~bypass;
  assign pop = out_ready & ~redirect_valid;
  fetch_fifo #(.DEPTH(DEPTH), .W(DATA_W + INSTR_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .pop_i(pop),
    .flush_i(redirect_valid),
    .wdata_i({resp_pc_q, imem_rdata}),
    .rdata_o(head),
    .count_o(fifo_cnt)
  );
  assign out_valid = bypass | (fifo_cnt != '0);
  assign out_instr = bypass ? imem_rdata : head[INSTR_W-1:0];
  assign out_pc = bypass ? resp_pc_q : head[DATA_W+INSTR_W-1:INSTR_W];
  assign out_updated_pc = out_pc + STEP;
  assign occupancy = fifo_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      resp_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inflight_q <= issue;
      resp_pc_q <= issue ? imem_addr : resp_pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized run against a queue-based reference model
module tb_fetch_unit;
  import fetch_pkg::*;
  localparam int DEPTH = 4;
  localparam logic [63:0] RESET_PC = 64'h0;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int LAT = BYP ? 1 : 2;
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;
  logic clk = 1'b0;
  logic rst, enable, redirect_valid, out_ready, imem_ren, out_valid;
  logic [63:0] redirect_pc, imem_addr, out_pc, out_updated_pc;
  logic [31:0] imem_rdata, out_instr;
  logic [2:0] occupancy;
  logic last_ren;
  logic [63:0] last_addr;
  int total = 0, bad = 0;

  fetch_unit #(.DATA_W(64), .INSTR_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .enable(enable), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_ren(imem_ren),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_updated_pc(out_updated_pc),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    last_ren <= imem_ren;
    last_addr <= imem_addr;
  end

  function automatic logic [31:0] mem_f(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ NOP;
  endfunction

  // one clock; the SRAM answers last cycle's read, otherwise drives junk
  task automatic tick();
    @(posedge clk);
    #1;
    imem_rdata = last_ren ? mem_f(last_addr) : $urandom;
  endtask

  task automatic do_reset();
    rst = 1; enable = 0; redirect_valid = 0; redirect_pc = '0; out_ready = 0;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; enable = 1; out_ready = 1; redirect_valid = 0; redirect_pc = '0;
    tick();
    tick();
    @(negedge clk);
    total++;
    if (imem_ren !== 1'b0 || out_valid !== 1'b0 || occupancy !== 3'd0) begin
      bad++; $display("FAIL reset_ctrl: ren=%b valid=%b occ=%0d want 0 0 0", imem_ren, out_valid, occupancy);
    end
    total++;
    if (out_pc !== 64'h0 || out_instr !== 32'h0 || out_updated_pc !== 64'h4) begin
      bad++; $display("FAIL reset_out: pc=%h instr=%h upd=%h want 0 0 4", out_pc, out_instr, out_updated_pc);
    end
    total++;
    if (imem_addr !== RESET_PC) begin
      bad++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC);
    end
    rst = 0;
  endtask

  task automatic test_stream();
    int n;
    logic [63:0] epc;
    do_reset();
    enable = 1; out_ready = 1; n = 0;
    @(negedge clk);
    while (imem_ren !== 1'b1 && n < 4) begin tick(); @(negedge clk); n++; end
    total++;
    if (imem_ren !== 1'b1) begin bad++; $display("FAIL stream_start: ren=%b want 1", imem_ren); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (imem_ren !== 1'b1 || imem_addr !== 64'(4 * i)) begin
        bad++; $display("FAIL stream_issue%0d: ren=%b addr=%h want 1 %h", i, imem_ren, imem_addr, 64'(4 * i));
      end
      total++;
      if (out_valid !== (i >= LAT)) begin
        bad++; $display("FAIL stream_valid%0d: got %b want %b", i, out_valid, (i >= LAT));
      end
      if (i >= LAT) begin
        epc = 64'(4 * (i - LAT));
        total++;
        if (out_pc !== epc || out_instr !== mem_f(epc) || out_updated_pc !== epc + 64'd4) begin
          bad++; $display("FAIL stream_out%0d: pc=%h instr=%h upd=%h want %h %h %h", i, out_pc, out_instr, out_updated_pc, epc, mem_f(epc), epc + 64'd4);
        end
      end
      total++;
      if (occupancy !== 3'((i >= 2 && !BYP) ? 1 : 0)) begin
        bad++; $display("FAIL stream_occ%0d: got %0d want %0d", i, occupancy, (i >= 2 && !BYP) ? 1 : 0);
      end
      tick();
      @(negedge clk);
    end
  endtask

  task automatic test_full();
    int iss, c;
    logic [63:0] got[$];
    do_reset();
    enable = 1; out_ready = 0; iss = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (imem_ren === 1'b1) iss++;
      tick();
    end
    @(negedge clk);
    total++;
    if (iss != 4) begin bad++; $display("FAIL full_issues: got %0d want 4", iss); end
    total++;
    if (occupancy !== 3'd4 || imem_ren !== 1'b0 || imem_addr !== 64'h10) begin
      bad++; $display("FAIL full_hold: occ=%0d ren=%b addr=%h want 4 0 10", occupancy, imem_ren, imem_addr);
    end
    out_ready = 1; c = 0;
    while (got.size() < 6 && c < 30) begin
      if (out_valid === 1'b1) got.push_back(out_pc);
      tick();
      @(negedge clk);
      c++;
    end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (k >= got.size() || got[k] !== 64'(4 * k)) begin
        bad++; $display("FAIL full_drain%0d: got %h want %h (n=%0d)", k, (k < got.size()) ? got[k] : 64'hx, 64'(4 * k), got.size());
      end
    end
  endtask

  task automatic test_redirect();
    int n, c;
    logic [63:0] got[$];
    do_reset();
    enable = 1; out_ready = 0; n = 0;
    @(negedge clk);
    while (occupancy !== 3'd3 && n < 10) begin tick(); @(negedge clk); n++; end
    total++;
    if (occupancy !== 3'd3) begin bad++; $display("FAIL redir_setup: occ=%0d want 3", occupancy); end
    redirect_valid = 1; redirect_pc = 64'h100;
    #1;
    total++;
    if (imem_ren !== 1'b1 || imem_addr !== 64'h100) begin
      bad++; $display("FAIL redir_issue: ren=%b addr=%h want 1 100", imem_ren, imem_addr);
    end
    tick();
    redirect_valid = 0;
    @(negedge clk);
    total++;
    if (occupancy !== 3'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL redir_flush: occ=%0d valid=%b want 0 0", occupancy, out_valid);
    end
    out_ready = 1; c = 0;
    while (got.size() < 3 && c < 20) begin
      if (out_valid === 1'b1) got.push_back(out_pc);
      tick();
      @(negedge clk);
      c++;
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (k >= got.size() || got[k] !== 64'h100 + 64'(4 * k)) begin
        bad++; $display("FAIL redir_seq%0d: got %h want %h", k, (k < got.size()) ? got[k] : 64'hx, 64'h100 + 64'(4 * k));
      end
    end
  endtask

  task automatic test_redirect_pop();
    int n, c;
    logic [63:0] got[$];
    do_reset();
    enable = 1; out_ready = 1; n = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 8) begin tick(); @(negedge clk); n++; end
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL rpop_setup: valid=%b want 1", out_valid); end
    redirect_valid = 1; redirect_pc = 64'h200;
    #1;
    total++;
    if (imem_ren !== 1'b1 || imem_addr !== 64'h200) begin
      bad++; $display("FAIL rpop_issue: ren=%b addr=%h want 1 200", imem_ren, imem_addr);
    end
    tick();
    redirect_valid = 0;
    @(negedge clk);
    total++;
    if (occupancy !== 3'd0) begin bad++; $display("FAIL rpop_flush: occ=%0d want 0", occupancy); end
    c = 0;
    while (got.size() < 2 && c < 20) begin
      if (out_valid === 1'b1) got.push_back(out_pc);
      tick();
      @(negedge clk);
      c++;
    end
    for (int k = 0; k < 2; k++) begin
      total++;
      if (k >= got.size() || got[k] !== 64'h200 + 64'(4 * k)) begin
        bad++; $display("FAIL rpop_seq%0d: got %h want %h", k, (k < got.size()) ? got[k] : 64'hx, 64'h200 + 64'(4 * k));
      end
    end
  endtask

  task automatic test_reset_mid();
    int c;
    logic [63:0] got[$];
    do_reset();
    enable = 1; out_ready = 1;
    for (int k = 0; k < 6; k++) tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
      bad++; $display("FAIL rmid_clear: valid=%b occ=%0d want 0 0", out_valid, occupancy);
    end
    total++;
    if (imem_addr !== RESET_PC || imem_ren !== 1'b0) begin
      bad++; $display("FAIL rmid_addr: addr=%h ren=%b want %h 0", imem_addr, imem_ren, RESET_PC);
    end
    c = 0;
    while (got.size() < 1 && c < 10) begin
      if (out_valid === 1'b1) got.push_back(out_pc);
      tick();
      @(negedge clk);
      c++;
    end
    total++;
    if (got.size() < 1 || got[0] !== RESET_PC) begin
      bad++; $display("FAIL rmid_first: got %h want %h (n=%0d)", (got.size() > 0) ? got[0] : 64'hx, RESET_PC, got.size());
    end
  endtask

  // reference: queue of fetched words, one pending SRAM read, and a next-fetch PC
  task automatic test_random();
    ent_t q[$];
    logic [63:0] m_pc, pend_pc, tgt, e_addr, epc;
    logic [31:0] ein;
    logic m_run, pend, e_ren, byp, e_valid;
    int sel;
    do_reset();
    m_pc = RESET_PC; m_run = 0; pend = 0; pend_pc = '0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      enable = ($urandom_range(0, 9) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      sel = $urandom_range(0, 2);
      redirect_pc = (sel == 0) ? {$urandom, $urandom} :
                    (sel == 1) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15))) :
                    64'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      tgt = redirect_pc & ~64'h3;
      e_ren = enable && (redirect_valid || (m_run && (q.size() + int'(pend)) < DEPTH));
      e_addr = redirect_valid ? tgt : m_pc;
      byp = BYP && pend && !redirect_valid && q.size() == 0 && out_ready;
      e_valid = (q.size() > 0) || byp;
      total++;
      if (imem_ren !== e_ren || imem_addr !== e_addr) begin
        bad++; $display("FAIL rand_issue@%0d: ren=%b addr=%h want %b %h", c, imem_ren, imem_addr, e_ren, e_addr);
      end
      total++;
      if (out_valid !== e_valid || occupancy !== 3'(q.size())) begin
        bad++; $display("FAIL rand_q@%0d: valid=%b occ=%0d want %b %0d", c, out_valid, occupancy, e_valid, q.size());
      end
      if (e_valid) begin
        epc = byp ? pend_pc : q[0].pc;
        ein = byp ? mem_f(pend_pc) : q[0].instr;
        total++;
        if (out_pc !== epc || out_instr !== ein || out_updated_pc !== epc + 64'd4) begin
          bad++; $display("FAIL rand_out@%0d: pc=%h instr=%h upd=%h want %h %h %h", c, out_pc, out_instr, out_updated_pc, epc, ein, epc + 64'd4);
        end
      end
      tick();
      if (rst) begin
        q.delete(); pend = 0; m_pc = RESET_PC; m_run = 0;
      end else begin
        if (redirect_valid) q.delete();
        else begin
          if (q.size() > 0 && out_ready) void'(q.pop_front());
          if (pend && !byp) q.push_back('{pend_pc, mem_f(pend_pc)});
        end
        pend = e_ren;
        pend_pc = e_addr;
        m_pc = e_ren ? e_addr + 64'd4 : (redirect_valid ? tgt : m_pc);
        m_run = enable;
      end
    end
    rst = 0;
  endtask

  initial begin
    imem_rdata = '0;
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_redirect_pop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
